// File: rtl/pipeline_pkg.sv
// Shared definitions for the decode stage and the ALU stage it feeds:
// opcodes (equal to ALU modes), instruction field positions and the issued bundle.
package pipeline_pkg;

    localparam int DATA_W  = 4;
    localparam int REG_AW  = 2;
    localparam int INSTR_W = 12;

    localparam logic [2:0] OP_NOP   = 3'b000;
    localparam logic [2:0] OP_ADD   = 3'b001;
    localparam logic [2:0] OP_LOAD  = 3'b010;
    localparam logic [2:0] OP_STORE = 3'b011;
    localparam logic [2:0] OP_LOADC = 3'b100;

    // rs2 and imm/addr share bit 3; which one applies depends on the opcode.
    localparam int OP_HI  = 11;
    localparam int OP_LO  = 9;
    localparam int RD_HI  = 8;
    localparam int RD_LO  = 7;
    localparam int RS1_HI = 6;
    localparam int RS1_LO = 5;
    localparam int RS2_HI = 4;
    localparam int RS2_LO = 3;
    localparam int IMM_HI = 3;
    localparam int IMM_LO = 0;

    typedef struct packed {
        logic              valid;
        logic [2:0]        mode;
        logic [DATA_W-1:0] operand1;
        logic [DATA_W-1:0] operand2;
        logic [REG_AW-1:0] rd;
        logic [DATA_W-1:0] addr;
        logic              we;
    } ex_bundle_t;

    // True when the instruction sources register r (ADD: rs1/rs2, STORE: rd).
    function automatic logic reads_reg(input logic [INSTR_W-1:0] instr,
                                       input logic [REG_AW-1:0]  r);
        logic hit;
        hit = 1'b0;
        case (instr[OP_HI:OP_LO])
            OP_ADD:   hit = (instr[RS1_HI:RS1_LO] == r) || (instr[RS2_HI:RS2_LO] == r);
            OP_STORE: hit = (instr[RD_HI:RD_LO] == r);
            default:  hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/reg_file.sv
// 2^REG_AW x DATA_W register file: three combinational read ports, one
// synchronous write port, and write-through so a same-cycle write is seen.
module reg_file
    import pipeline_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [REG_AW-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [REG_AW-1:0] raddr_a,
    input  logic [REG_AW-1:0] raddr_b,
    input  logic [REG_AW-1:0] raddr_c,
    output logic [DATA_W-1:0] rdata_a,
    output logic [DATA_W-1:0] rdata_b,
    output logic [DATA_W-1:0] rdata_c
);

    localparam int NREGS = 1 << REG_AW;

    logic [DATA_W-1:0] regs_q [NREGS];
    logic [DATA_W-1:0] regs_d [NREGS];

    always_comb begin
        regs_d = regs_q;
        if (we) begin
            regs_d[waddr] = wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    assign rdata_a = (we && waddr == raddr_a) ? wdata : regs_q[raddr_a];
    assign rdata_b = (we && waddr == raddr_b) ? wdata : regs_q[raddr_b];
    assign rdata_c = (we && waddr == raddr_c) ? wdata : regs_q[raddr_c];

endmodule

// File: rtl/decode_stage.sv
// Decode / operand-fetch stage: decodes 12-bit instructions, reads operands with
// ALU-result and write-back bypass, inserts one bubble on load-use, registers the bundle.
module decode_stage
    import pipeline_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic [INSTR_W-1:0] in_instr,
    output logic               in_ready,
    input  logic               ex_stall,
    output logic               ex_valid,
    output logic [2:0]         ex_mode,
    output logic [DATA_W-1:0]  ex_operand1,
    output logic [DATA_W-1:0]  ex_operand2,
    output logic [REG_AW-1:0]  ex_rd,
    output logic [DATA_W-1:0]  ex_addr,
    output logic               ex_we,
    input  logic               fwd_en,
    input  logic [REG_AW-1:0]  fwd_addr,
    input  logic [DATA_W-1:0]  fwd_data,
    input  logic               wb_en,
    input  logic [REG_AW-1:0]  wb_addr,
    input  logic [DATA_W-1:0]  wb_data
);

    logic [2:0]        op;
    logic [REG_AW-1:0] rd_f;
    logic [REG_AW-1:0] rs1_f;
    logic [REG_AW-1:0] rs2_f;
    logic [DATA_W-1:0] imm_f;

    assign op    = in_instr[OP_HI:OP_LO];
    assign rd_f  = in_instr[RD_HI:RD_LO];
    assign rs1_f = in_instr[RS1_HI:RS1_LO];
    assign rs2_f = in_instr[RS2_HI:RS2_LO];
    assign imm_f = in_instr[IMM_HI:IMM_LO];

    logic [DATA_W-1:0] rf_rs1;
    logic [DATA_W-1:0] rf_rs2;
    logic [DATA_W-1:0] rf_rd;

    reg_file u_reg_file (
        .clk     (clk),
        .rst     (rst),
        .we      (wb_en),
        .waddr   (wb_addr),
        .wdata   (wb_data),
        .raddr_a (rs1_f),
        .raddr_b (rs2_f),
        .raddr_c (rd_f),
        .rdata_a (rf_rs1),
        .rdata_b (rf_rs2),
        .rdata_c (rf_rd)
    );

    // The register file already folds in the wb bypass, so only fwd sits above it.
    logic [DATA_W-1:0] val_rs1;
    logic [DATA_W-1:0] val_rs2;
    logic [DATA_W-1:0] val_rd;

    assign val_rs1 = (fwd_en && fwd_addr == rs1_f) ? fwd_data : rf_rs1;
    assign val_rs2 = (fwd_en && fwd_addr == rs2_f) ? fwd_data : rf_rs2;
    assign val_rd  = (fwd_en && fwd_addr == rd_f)  ? fwd_data : rf_rd;

    ex_bundle_t        ex_q;
    ex_bundle_t        ex_d;
    ex_bundle_t        dec;
    logic              ld_pend_q;
    logic              ld_pend_d;
    logic [REG_AW-1:0] ld_rd_q;
    logic [REG_AW-1:0] ld_rd_d;
    logic              load_use_hazard;

    // Handshake: fetch transfers when in_valid && in_ready; ex_valid marks the
    // registered bundle, which is frozen for as long as ex_stall is high.
    assign load_use_hazard = in_valid && ld_pend_q && reads_reg(in_instr, ld_rd_q);
    assign in_ready        = !rst && !ex_stall && !load_use_hazard;

    always_comb begin
        dec       = '0;
        dec.valid = 1'b1;
        case (op)
            OP_ADD: begin
                dec.mode     = OP_ADD;
                dec.operand1 = val_rs1;
                dec.operand2 = val_rs2;
                dec.rd       = rd_f;
                dec.we       = 1'b1;
            end
            OP_LOAD: begin
                dec.mode = OP_LOAD;
                dec.rd   = rd_f;
                dec.addr = imm_f;
                dec.we   = 1'b1;
            end
            OP_STORE: begin
                dec.mode     = OP_STORE;
                dec.operand1 = val_rd;
                dec.rd       = rd_f;
                dec.addr     = imm_f;
            end
            OP_LOADC: begin
                dec.mode     = OP_LOADC;
                dec.operand1 = imm_f;
                dec.rd       = rd_f;
                dec.we       = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        ex_d      = ex_q;
        ld_pend_d = ld_pend_q;
        ld_rd_d   = ld_rd_q;
        if (!ex_stall) begin
            if (load_use_hazard) begin
                ex_d       = '0;
                ex_d.valid = 1'b1;
                ld_pend_d  = 1'b0;
            end else if (in_valid) begin
                ex_d      = dec;
                ld_pend_d = (op == OP_LOAD);
                ld_rd_d   = rd_f;
            end else begin
                ex_d      = '0;
                ld_pend_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q      <= '0;
            ld_pend_q <= 1'b0;
            ld_rd_q   <= '0;
        end else begin
            ex_q      <= ex_d;
            ld_pend_q <= ld_pend_d;
            ld_rd_q   <= ld_rd_d;
        end
    end

    assign ex_valid    = ex_q.valid;
    assign ex_mode     = ex_q.mode;
    assign ex_operand1 = ex_q.operand1;
    assign ex_operand2 = ex_q.operand2;
    assign ex_rd       = ex_q.rd;
    assign ex_addr     = ex_q.addr;
    assign ex_we       = ex_q.we;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: an instruction-level model predicts every
// bundle and in_ready; literal checks pin the model to hand-computed values.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [11:0] in_instr;
    logic        in_ready;
    logic        ex_stall;
    logic        ex_valid;
    logic [2:0]  ex_mode;
    logic [3:0]  ex_operand1;
    logic [3:0]  ex_operand2;
    logic [1:0]  ex_rd;
    logic [3:0]  ex_addr;
    logic        ex_we;
    logic        fwd_en;
    logic [1:0]  fwd_addr;
    logic [3:0]  fwd_data;
    logic        wb_en;
    logic [1:0]  wb_addr;
    logic [3:0]  wb_data;

    int n_tests = 0;
    int n_fail  = 0;

    decode_stage dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_instr    (in_instr),
        .in_ready    (in_ready),
        .ex_stall    (ex_stall),
        .ex_valid    (ex_valid),
        .ex_mode     (ex_mode),
        .ex_operand1 (ex_operand1),
        .ex_operand2 (ex_operand2),
        .ex_rd       (ex_rd),
        .ex_addr     (ex_addr),
        .ex_we       (ex_we),
        .fwd_en      (fwd_en),
        .fwd_addr    (fwd_addr),
        .fwd_data    (fwd_data),
        .wb_en       (wb_en),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Instruction builders
    function automatic logic [11:0] mk_r(input logic [2:0] op, input logic [1:0] rd,
                                         input logic [1:0] rs1, input logic [1:0] rs2);
        return {op, rd, rs1, rs2, 3'b000};
    endfunction

    function automatic logic [11:0] mk_i(input logic [2:0] op, input logic [1:0] rd,
                                         input logic [3:0] imm);
        return {op, rd, 3'b000, imm};
    endfunction

    // Behavioural model: register array, "last issue was LOAD to r" flag, bundle queue
    logic [3:0]  m_regs [4] = '{4'd0, 4'd0, 4'd0, 4'd0};
    logic        m_pend     = 1'b0;
    logic [1:0]  m_pend_rd  = 2'd0;
    logic [18:0] m_cur      = '0;
    logic [18:0] exp_q [$];
    logic [18:0] dut_b;

    assign dut_b = {ex_valid, ex_mode, ex_operand1, ex_operand2, ex_rd, ex_addr, ex_we};

    function automatic logic [18:0] pack(input logic v, input logic [2:0] m, input logic [3:0] o1,
                                         input logic [3:0] o2, input logic [1:0] rd,
                                         input logic [3:0] a, input logic we);
        return {v, m, o1, o2, rd, a, we};
    endfunction

    function automatic logic [3:0] m_src(input logic [1:0] r);
        if (fwd_en && fwd_addr == r) return fwd_data;
        if (wb_en && wb_addr == r) return wb_data;
        return m_regs[r];
    endfunction

    function automatic logic m_uses(input logic [11:0] i, input logic [1:0] r);
        if (i[11:9] == 3'd1) return (i[6:5] == r) || (i[4:3] == r);
        if (i[11:9] == 3'd3) return i[8:7] == r;
        return 1'b0;
    endfunction

    function automatic logic [18:0] m_decode(input logic [11:0] i);
        case (i[11:9])
            3'd1:    return pack(1'b1, 3'd1, m_src(i[6:5]), m_src(i[4:3]), i[8:7], 4'd0, 1'b1);
            3'd2:    return pack(1'b1, 3'd2, 4'd0, 4'd0, i[8:7], i[3:0], 1'b1);
            3'd3:    return pack(1'b1, 3'd3, m_src(i[8:7]), 4'd0, i[8:7], i[3:0], 1'b0);
            3'd4:    return pack(1'b1, 3'd4, i[3:0], 4'd0, i[8:7], 4'd0, 1'b1);
            default: return pack(1'b1, 3'd0, 4'd0, 4'd0, 2'd0, 4'd0, 1'b0);
        endcase
    endfunction

    always @(posedge clk) begin
        logic [18:0] nxt;
        nxt = m_cur;
        if (rst) begin
            nxt    = '0;
            m_pend = 1'b0;
            for (int i = 0; i < 4; i++) m_regs[i] = 4'd0;
        end else begin
            if (!ex_stall) begin
                if (in_valid && m_pend && m_uses(in_instr, m_pend_rd)) begin
                    nxt    = pack(1'b1, 3'd0, 4'd0, 4'd0, 2'd0, 4'd0, 1'b0);
                    m_pend = 1'b0;
                end else if (in_valid) begin
                    nxt       = m_decode(in_instr);
                    m_pend    = (in_instr[11:9] == 3'd2);
                    m_pend_rd = in_instr[8:7];
                end else begin
                    nxt    = '0;
                    m_pend = 1'b0;
                end
            end
            if (wb_en) m_regs[wb_addr] = wb_data;
        end
        m_cur = nxt;
        exp_q.push_back(nxt);
    end

    // scoreboard compare, away from the active edge
    always @(negedge clk) begin
        logic [18:0] e;
        logic        exp_rdy;
        #2;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("bundle", {13'd0, dut_b}, {13'd0, e});
        end
        exp_rdy = !rst && !ex_stall && !(in_valid && m_pend && m_uses(in_instr, m_pend_rd));
        chk("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
    end

    // driver tasks
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [11:0] i);
        in_valid = 1'b1;
        in_instr = i;
        cyc();
        in_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_instr = '0; ex_stall = 1'b0;
        fwd_en = 1'b0; fwd_addr = '0; fwd_data = '0;
        wb_en = 1'b0; wb_addr = '0; wb_data = '0;
        repeat (2) cyc();
        chk("rst_valid", ex_valid, 0);
        chk("rst_mode", ex_mode, 0);
        chk("rst_ready", in_ready, 0);
        rst = 1'b0;

        // LOADC r1 <- 7
        issue(mk_i(3'd4, 2'd1, 4'd7));
        chk("loadc_valid", ex_valid, 1);
        chk("loadc_mode", ex_mode, 4);
        chk("loadc_op1", ex_operand1, 7);
        chk("loadc_rd", ex_rd, 1);
        chk("loadc_we", ex_we, 1);
        cyc();
        chk("idle_valid", ex_valid, 0);

        // R1=3, R2=5 then ADD r3 = r1 + r2
        wb_en = 1'b1; wb_addr = 2'd1; wb_data = 4'd3; cyc();
        wb_addr = 2'd2; wb_data = 4'd5; cyc();
        wb_en = 1'b0;
        issue(mk_r(3'd1, 2'd3, 2'd1, 2'd2));
        chk("add_mode", ex_mode, 1);
        chk("add_op1", ex_operand1, 3);
        chk("add_op2", ex_operand2, 5);
        chk("add_we", ex_we, 1);

        // fwd beats wb on the same register; then wb alone
        fwd_en = 1'b1; fwd_addr = 2'd2; fwd_data = 4'd9;
        wb_en = 1'b1; wb_addr = 2'd2; wb_data = 4'd4;
        issue(mk_r(3'd1, 2'd0, 2'd0, 2'd2));
        chk("fwd_op2", ex_operand2, 9);
        fwd_en = 1'b0;
        issue(mk_r(3'd1, 2'd0, 2'd0, 2'd2));
        chk("wb_op2", ex_operand2, 4);
        wb_en = 1'b0;

        // load-use on ADD: one bubble, loaded value arrives by wb bypass
        issue(mk_i(3'd2, 2'd2, 4'hA));
        chk("load_mode", ex_mode, 2);
        chk("load_addr", ex_addr, 4'hA);
        in_valid = 1'b1; in_instr = mk_r(3'd1, 2'd3, 2'd2, 2'd0);
        #1;
        chk("hz_ready", in_ready, 0);
        cyc();
        chk("bubble_valid", ex_valid, 1);
        chk("bubble_mode", ex_mode, 0);
        chk("bubble_we", ex_we, 0);
        chk("post_bubble_ready", in_ready, 1);
        wb_en = 1'b1; wb_addr = 2'd2; wb_data = 4'hC;
        cyc();
        in_valid = 1'b0; wb_en = 1'b0;
        chk("hz_add_mode", ex_mode, 1);
        chk("hz_add_op1", ex_operand1, 4'hC);

        // ex_stall for 3 cycles with a wb to R1 during the stall
        issue(mk_i(3'd4, 2'd3, 4'd5));
        ex_stall = 1'b1; in_valid = 1'b1; in_instr = mk_r(3'd1, 2'd0, 2'd1, 2'd1);
        wb_en = 1'b1; wb_addr = 2'd1; wb_data = 4'hE;
        #1;
        chk("stall_ready", in_ready, 0);
        cyc();
        wb_en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("stall_mode", ex_mode, 4);
            chk("stall_op1", ex_operand1, 5);
            if (k < 2) cyc();
        end
        ex_stall = 1'b0;
        cyc();
        in_valid = 1'b0;
        chk("after_stall_op1", ex_operand1, 4'hE);
        chk("after_stall_op2", ex_operand2, 4'hE);

        // hazard coinciding with ex_stall: bubble only after the stall drops
        issue(mk_i(3'd2, 2'd1, 4'd3));
        in_valid = 1'b1; in_instr = mk_r(3'd1, 2'd2, 2'd1, 2'd0); ex_stall = 1'b1;
        repeat (2) cyc();
        chk("hz_stall_mode", ex_mode, 2);
        ex_stall = 1'b0;
        cyc();
        chk("hz_stall_bubble", ex_mode, 0);
        cyc();
        in_valid = 1'b0;
        chk("hz_stall_add", ex_operand1, 4'hE);

        // load-use on STORE rd; then an independent ADD after LOAD has no hazard
        issue(mk_i(3'd2, 2'd0, 4'd1));
        in_valid = 1'b1; in_instr = mk_i(3'd3, 2'd0, 4'd4);
        #1;
        chk("st_hz_ready", in_ready, 0);
        cyc();
        wb_en = 1'b1; wb_addr = 2'd0; wb_data = 4'd6;
        cyc();
        in_valid = 1'b0; wb_en = 1'b0;
        chk("store_mode", ex_mode, 3);
        chk("store_op1", ex_operand1, 6);
        chk("store_addr", ex_addr, 4);
        issue(mk_i(3'd2, 2'd1, 4'd2));
        in_valid = 1'b1; in_instr = mk_r(3'd1, 2'd2, 2'd2, 2'd3);
        #1;
        chk("nohz_ready", in_ready, 1);
        cyc();
        in_valid = 1'b0;

        // illegal opcode
        issue(mk_i(3'd7, 2'd2, 4'd5));
        chk("ill_valid", ex_valid, 1);
        chk("ill_mode", ex_mode, 0);
        chk("ill_we", ex_we, 0);

        // reset mid-stall, then registers read back as 0
        issue(mk_i(3'd4, 2'd2, 4'd9));
        ex_stall = 1'b1;
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0; ex_stall = 1'b0;
        chk("rst_stall_valid", ex_valid, 0);
        chk("rst_stall_op1", ex_operand1, 0);
        chk("rst_stall_rd", ex_rd, 0);
        issue(mk_r(3'd1, 2'd0, 2'd1, 2'd2));
        chk("rst_regs_op1", ex_operand1, 0);
        chk("rst_regs_op2", ex_operand2, 0);
        repeat (2) cyc();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
